// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are registered toward the ALU and each result returns tagged with its requester id.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_ctr,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_ctr,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [3:0]       alu_ctr,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_grant_q;
    logic [WIDTH-1:0] alu_in1_q, alu_in2_q;
    logic [3:0]       alu_ctr_q;
    logic             rsp_id_q, rsp_zero_q, rsp_err_q;
    logic [WIDTH-1:0] rsp_result_q;

    logic             grant_id;
    logic             accept;
    logic             sel_legal;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [3:0]       sel_ctr;

    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = req1_valid && !req0_valid;
        end
        accept  = (state_q == IDLE) && (req0_valid || req1_valid);
        sel_a   = grant_id ? req1_a   : req0_a;
        sel_b   = grant_id ? req1_b   : req0_b;
        sel_ctr = grant_id ? req1_ctr : req0_ctr;
        case (sel_ctr)
            4'd0, 4'd1, 4'd2, 4'd6, 4'd7: sel_legal = 1'b1;
            default:                      sel_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = sel_legal ? EXEC : RESP;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = (state_q == IDLE) && req0_valid && !grant_id;
        req1_ready = (state_q == IDLE) && req1_valid &&  grant_id;
        rsp_valid  = (state_q == RESP);
        busy       = (state_q != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            alu_in1_q    <= '0;
            alu_in2_q    <= '0;
            alu_ctr_q    <= '0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            if (accept) begin
                last_grant_q <= grant_id;
                rsp_id_q     <= grant_id;
                if (sel_legal) begin
                    alu_in1_q <= sel_a;
                    alu_in2_q <= sel_b;
                    alu_ctr_q <= sel_ctr;
                end else begin
                    // Illegal codes never reach the ALU; answer with an error directly.
                    rsp_result_q <= '0;
                    rsp_zero_q   <= 1'b0;
                    rsp_err_q    <= 1'b1;
                end
            end
            if (state_q == EXEC) begin
                rsp_result_q <= alu_res;
                rsp_zero_q   <= alu_zero;
                rsp_err_q    <= 1'b0;
            end
        end
    end

    assign alu_in1    = alu_in1_q;
    assign alu_in2    = alu_in2_q;
    assign alu_ctr    = alu_ctr_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_err    = rsp_err_q;

endmodule
